// File: rtl/decode_pkg.sv
// Shared definitions for the 16-bit instruction decoder.
// Holds opcodes, ALU codes, field positions, the decoded bundle and the decode function.
package decode_pkg;

    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 12;
    localparam int RD_HI    = 11;
    localparam int RD_LO    = 9;
    localparam int RS1_HI   = 8;
    localparam int RS1_LO   = 6;
    localparam int RS2_HI   = 5;
    localparam int RS2_LO   = 3;
    localparam int IMM6_HI  = 5;
    localparam int IMM12_HI = 11;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_ADDI  = 4'h4,
        OP_LOAD  = 4'h5,
        OP_STORE = 4'h6,
        OP_BEQ   = 4'h7,
        OP_JMP   = 4'h8,
        OP_NOP   = 4'hF
    } opcode_e;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    typedef struct packed {
        logic [2:0]  reg1;
        logic [2:0]  reg2;
        logic [2:0]  reg3;
        logic        reg_write;
        logic [2:0]  alu_op;
        logic        use_imm;
        logic [15:0] imm;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } bundle_t;

    function automatic logic writes_rd(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LOAD};
    endfunction

    function automatic logic reads_rs1(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LOAD, OP_STORE, OP_BEQ};
    endfunction

    function automatic logic reads_rs2(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    endfunction

    // STORE and BEQ read rd as their second source operand.
    function automatic logic reads_rd(input logic [3:0] op);
        return op inside {OP_STORE, OP_BEQ};
    endfunction

    function automatic bundle_t decode(input logic [15:0] w);
        bundle_t    b;
        logic [3:0] op;
        op     = w[OPC_HI:OPC_LO];
        b      = '0;
        b.reg1 = w[RS1_HI:RS1_LO];
        b.reg2 = w[RS2_HI:RS2_LO];
        b.reg3 = w[RD_HI:RD_LO];
        b.imm  = {{10{w[IMM6_HI]}}, w[IMM6_HI:0]};
        case (op)
            OP_ADD:   b.reg_write = 1'b1;
            OP_SUB:   begin b.reg_write = 1'b1; b.alu_op = ALU_SUB; end
            OP_AND:   begin b.reg_write = 1'b1; b.alu_op = ALU_AND; end
            OP_OR:    begin b.reg_write = 1'b1; b.alu_op = ALU_OR;  end
            OP_ADDI:  begin b.reg_write = 1'b1; b.use_imm = 1'b1; end
            OP_LOAD:  begin b.reg_write = 1'b1; b.use_imm = 1'b1; b.mem_read = 1'b1; end
            OP_STORE: begin b.reg2 = w[RD_HI:RD_LO]; b.use_imm = 1'b1; b.mem_write = 1'b1; end
            OP_BEQ:   begin b.reg2 = w[RD_HI:RD_LO]; b.alu_op = ALU_SUB; b.branch = 1'b1; end
            OP_JMP:   begin b.jump = 1'b1; b.imm = {{4{w[IMM12_HI]}}, w[IMM12_HI:0]}; end
            OP_NOP:   b.alu_op = ALU_ADD;
            default:  b.illegal = 1'b1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Pending-write mask and read/write hazard detection for the decoder.
// Write-back clears take effect combinationally in the same cycle.
module decode_scoreboard
    import decode_pkg::*;
#(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  accept,
    input  logic [3:0]            op,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    output logic                  hazard
);
    localparam int NREG = 1 << REG_ADDR_W;

    logic [NREG-1:0]       pending_reg;
    logic [NREG-1:0]       pending_next;
    logic [NREG-1:0]       pending_eff;
    logic [NREG-1:0]       wb_clear;
    logic [NREG-1:0]       set_mask;
    logic [REG_ADDR_W-1:0] src2;
    logic                  set_en;

    assign set_en = accept & writes_rd(op);
    assign src2   = reads_rd(op) ? rd : rs2;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_bit
            assign wb_clear[gi] = wb_valid & (wb_reg == REG_ADDR_W'(gi));
            assign set_mask[gi] = set_en & (rd == REG_ADDR_W'(gi));
        end
    endgenerate

    assign pending_eff = pending_reg & ~wb_clear;
    // A new write to a register being retired this cycle must remain pending.
    assign pending_next = pending_eff | set_mask;

    assign hazard = in_valid &
                    ((reads_rs1(op) & pending_eff[rs1]) |
                     ((reads_rs2(op) | reads_rd(op)) & pending_eff[src2]) |
                     (writes_rd(op) & pending_eff[rd]));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

endmodule

// File: rtl/instr_decode.sv
// Single-stage instruction decoder with valid/ready handshake on both sides.
// Define DECODE_SCOREBOARD_EN to enable the register-hazard scoreboard.
module instr_decode
    import decode_pkg::*;
#(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] reg1,
    output logic [REG_ADDR_W-1:0] reg2,
    output logic [REG_ADDR_W-1:0] reg3,
    output logic                  regWrite,
    output logic [2:0]            alu_op,
    output logic                  use_imm,
    output logic [15:0]           imm,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  branch,
    output logic                  jump,
    output logic                  illegal,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_reg
);
    bundle_t bundle_reg;
    logic    out_valid_reg;
    logic    hazard;
    logic    accept;

`ifdef DECODE_SCOREBOARD_EN
    decode_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_sb (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .accept   (accept),
        .op       (instr[OPC_HI:OPC_LO]),
        .rd       (instr[RD_HI:RD_LO]),
        .rs1      (instr[RS1_HI:RS1_LO]),
        .rs2      (instr[RS2_HI:RS2_LO]),
        .wb_valid (wb_valid),
        .wb_reg   (wb_reg),
        .hazard   (hazard)
    );
`else
    logic unused_wb;
    assign unused_wb = wb_valid ^ (^wb_reg);
    assign hazard    = 1'b0;
`endif

    assign in_ready = (~out_valid_reg | out_ready) & ~hazard;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            bundle_reg    <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            bundle_reg    <= decode(instr);
        end else if (out_ready & out_valid_reg) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign reg1      = bundle_reg.reg1;
    assign reg2      = bundle_reg.reg2;
    assign reg3      = bundle_reg.reg3;
    assign regWrite  = bundle_reg.reg_write;
    assign alu_op    = bundle_reg.alu_op;
    assign use_imm   = bundle_reg.use_imm;
    assign imm       = bundle_reg.imm;
    assign mem_read  = bundle_reg.mem_read;
    assign mem_write = bundle_reg.mem_write;
    assign branch    = bundle_reg.branch;
    assign jump      = bundle_reg.jump;
    assign illegal   = bundle_reg.illegal;

endmodule
